// File: rtl/stopwatch_lap_core_pkg.sv
// Shared types and helpers for the stopwatch/lap core.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package stopwatch_lap_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Radix table: digits 3 and 5 are tens-of-seconds / tens-of-minutes (0-5),
  // every other digit is a full decimal digit (0-9).
  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
  endfunction

  // Only mm:ss.cc (6) and hh:mm:ss.cc (8) layouts are meaningful.
  function automatic bit digits_legal(input int d);
    return (d == 6) || (d == 8);
  endfunction

endpackage

// File: rtl/stopwatch_lap_core_bcd_digit_cnt.sv
// One BCD digit of the time counter, counting up or down with wrap at MAX.
// Latency: q updates on the clock after cin/load; cout is combinational.
// Backpressure: none; cin is the only advance request and is always taken.
// Ports: clk/rst clock and async active-high reset; load/load_val synchronous
//   load (wins over cin); dir 0 up, 1 down; cin carry/borrow in; q digit value;
//   cout carry (up, at MAX) or borrow (down, at 0) to the next digit.
module stopwatch_lap_core_bcd_digit_cnt #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dir,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);

  assign cout = cin & (dir ? (q == 4'd0) : (q == MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_val;
    end else if (cin) begin
      if (dir) begin
        q <= (q == 4'd0) ? MAX : q - 4'd1;
      end else begin
        // >= so an out-of-range value still returns to a legal digit
        q <= (q >= MAX) ? 4'd0 : q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch/timer core: BCD up/down time counter, run/pause/expire FSM, lap ring buffer.
// Latency: data_rt/state update 1 cycle after tick/flag; data_disp registered, 1 cycle behind.
// Backpressure: none; pulse flags are single-cycle and resolved clr > sta_sto > lap > read.
// Ports: sys_clk/rst clock and async active-high reset; tick 100 Hz enable;
//   sta_sto_flag/lap_flag/read_flag/clr_flag key pulses; dir count direction;
//   preset countdown start; data_rt live time; data_disp live or lap; disp_mode,
//   lap_idx review state; cnt_en running; lap_cnt/full lap fill; ovf, expired status.
module stopwatch_lap_core
  import stopwatch_lap_core_pkg::*;
#(
  parameter  int DIGITS    = 8,
  parameter  int LAP_DEPTH = 8,
  localparam int LAP_AW    = $clog2(LAP_DEPTH),
  localparam int W         = 4 * DIGITS
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              sta_sto_flag,
  input  logic              lap_flag,
  input  logic              read_flag,
  input  logic              clr_flag,
  input  logic              dir,
  input  logic [W-1:0]      preset,
  output logic [W-1:0]      data_rt,
  output logic [W-1:0]      data_disp,
  output logic              disp_mode,
  output logic              cnt_en,
  output logic [LAP_AW:0]   lap_cnt,
  output logic [LAP_AW-1:0] lap_idx,
  output logic              full,
  output logic              ovf,
  output logic              expired
);

  if (!digits_legal(DIGITS)) begin : g_bad_digits
    $error("stopwatch_lap_core: DIGITS must be 6 or 8");
  end

  localparam logic [LAP_AW:0] LAP_FULL = (LAP_AW+1)'(LAP_DEPTH);
  localparam logic [LAP_AW:0] ONE_EXT  = (LAP_AW+1)'(1);

  state_t              state, state_nx;
  logic                dir_q;
  logic [LAP_AW-1:0]   wr_ptr, rd_addr;
  logic [W-1:0]        lap_mem [LAP_DEPTH];
  logic [DIGITS:0]     carry;
  logic                rt_zero, step, expire_hit;
  logic                sta_eff, lap_eff, read_eff;

  assign rt_zero = (data_rt == '0);

  // Flag arbitration: a lower-priority pulse is dropped whenever a higher one
  // is present and would itself be acted on. In review, start/stop and lap
  // are ignored, so they no longer mask read.
  assign sta_eff  = sta_sto_flag & ~clr_flag & ~disp_mode & (state != ST_DONE);
  assign lap_eff  = lap_flag & ~clr_flag & ~sta_sto_flag & ~disp_mode & (state == ST_RUN);
  assign read_eff = read_flag & ~clr_flag & ~(~disp_mode & (sta_sto_flag | lap_flag));

  // Counting follows the registered state, so a stop pulse on a tick cycle
  // still counts that tick. A countdown at zero holds instead of wrapping.
  assign expire_hit = (state == ST_RUN) & dir_q & rt_zero & tick;
  assign step       = (state == ST_RUN) & tick & ~(dir_q & rt_zero) & ~clr_flag;
  assign carry[0]   = step;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    stopwatch_lap_core_bcd_digit_cnt #(
      .MAX(digit_max(i))
    ) u_digit (
      .clk      (sys_clk),
      .rst      (rst),
      .load     (clr_flag),
      .load_val (dir ? preset[4*i +: 4] : 4'd0),
      .dir      (dir_q),
      .cin      (carry[i]),
      .q        (data_rt[4*i +: 4]),
      .cout     (carry[i+1])
    );
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (clr_flag) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (sta_eff) state_nx = ST_RUN;
        ST_RUN: begin
          if (sta_eff)         state_nx = ST_PAUSE;
          else if (expire_hit) state_nx = ST_DONE;
        end
        ST_PAUSE: if (sta_eff) state_nx = ST_RUN;
        ST_DONE:  state_nx = ST_DONE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  assign cnt_en  = (state == ST_RUN);
  assign expired = (state == ST_DONE);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      dir_q <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (state == ST_IDLE && sta_eff) dir_q <= dir;
      if (clr_flag)                    ovf <= 1'b0;
      else if (carry[DIGITS] & ~dir_q) ovf <= 1'b1;
    end
  end

  // Lap bookkeeping and review navigation.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      lap_cnt   <= '0;
      disp_mode <= 1'b0;
      lap_idx   <= '0;
    end else if (clr_flag) begin
      wr_ptr    <= '0;
      lap_cnt   <= '0;
      disp_mode <= 1'b0;
      lap_idx   <= '0;
    end else begin
      if (lap_eff) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (lap_cnt != LAP_FULL) lap_cnt <= lap_cnt + ONE_EXT;
      end
      if (read_eff) begin
        if (!disp_mode) begin
          if (lap_cnt != '0) begin
            disp_mode <= 1'b1;
            lap_idx   <= '0;
          end
        end else if (({1'b0, lap_idx} + ONE_EXT) < lap_cnt) begin
          lap_idx <= lap_idx + 1'b1;
        end else begin
          disp_mode <= 1'b0;
          lap_idx   <= '0;
        end
      end
    end
  end

  assign full = (lap_cnt == LAP_FULL);

  // Lap storage has no reset; only entries below lap_cnt are ever shown.
  always_ff @(posedge sys_clk) begin
    if (lap_eff) lap_mem[wr_ptr] <= data_rt;
  end

  // Index 0 is the newest lap, i.e. the slot just behind the write pointer.
  assign rd_addr = wr_ptr - lap_idx - LAP_AW'(1);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      data_disp <= '0;
    end else begin
      data_disp <= disp_mode ? lap_mem[rd_addr] : data_rt;
    end
  end

endmodule

// File: tb/tb_stopwatch_lap_core.sv
module tb_stopwatch_lap_core;

  localparam int DIGITS    = 6;
  localparam int LAP_DEPTH = 4;
  localparam int LAP_AW    = 2;
  localparam int W         = 4 * DIGITS;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick = 1'b0, sta_sto_flag = 1'b0, lap_flag = 1'b0;
  logic              read_flag = 1'b0, clr_flag = 1'b0, dir = 1'b0;
  logic [W-1:0]      preset = '0;
  logic [W-1:0]      data_rt, data_disp;
  logic              disp_mode, cnt_en, full, ovf, expired;
  logic [LAP_AW:0]   lap_cnt;
  logic [LAP_AW-1:0] lap_idx;

  int checks = 0;
  int errors = 0;

  stopwatch_lap_core #(.DIGITS(DIGITS), .LAP_DEPTH(LAP_DEPTH)) dut (
    .sys_clk(sys_clk), .rst(rst), .tick(tick), .sta_sto_flag(sta_sto_flag),
    .lap_flag(lap_flag), .read_flag(read_flag), .clr_flag(clr_flag), .dir(dir),
    .preset(preset), .data_rt(data_rt), .data_disp(data_disp), .disp_mode(disp_mode),
    .cnt_en(cnt_en), .lap_cnt(lap_cnt), .lap_idx(lap_idx), .full(full), .ovf(ovf),
    .expired(expired)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [4:0]        flags;   // {tick, sta_sto, lap, read, clr}
    logic [W-1:0]      e_rt;
    logic              e_en;
    logic [LAP_AW:0]   e_cnt;
    logic              e_full;
    logic              e_dm;
    logic [LAP_AW-1:0] e_idx;
    logic [W-1:0]      e_disp;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [4:0] f, input logic [W-1:0] rt,
                         input logic en, input logic [LAP_AW:0] cnt, input logic fl,
                         input logic dm, input logic [LAP_AW-1:0] idx, input logic [W-1:0] disp);
    tbl[i].flags = f;   tbl[i].e_rt = rt;   tbl[i].e_en = en;   tbl[i].e_cnt = cnt;
    tbl[i].e_full = fl; tbl[i].e_dm = dm;   tbl[i].e_idx = idx; tbl[i].e_disp = disp;
  endtask

  // One clock with the given pulses; outputs are stable 1 time unit after the edge.
  task automatic step(input logic [4:0] f);
    {tick, sta_sto_flag, lap_flag, read_flag, clr_flag} = f;
    @(posedge sys_clk);
    #1;
    {tick, sta_sto_flag, lap_flag, read_flag, clr_flag} = 5'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(posedge sys_clk);
    #1;
    tick = 1'b0;
  endtask

  localparam logic [4:0] F_TICK = 5'b10000, F_STA = 5'b01000, F_LAP = 5'b00100,
                         F_RD   = 5'b00010, F_CLR = 5'b00001, F_NONE = 5'b00000;

  initial begin
    // Lap/review walk with LAP_DEPTH=4: laps A=1,B=2,C=4,D=5,E=6; E overwrites A.
    // data_disp lags one cycle, so its column reflects the state before each edge.
    set_vec( 0, F_TICK,         24'h1, 1'b1, 3'd0, 1'b0, 1'b0, 2'd0, 24'h0);
    set_vec( 1, F_LAP,          24'h1, 1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 24'h1);
    set_vec( 2, F_TICK,         24'h2, 1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 24'h1);
    set_vec( 3, F_TICK | F_LAP, 24'h3, 1'b1, 3'd2, 1'b0, 1'b0, 2'd0, 24'h2);
    set_vec( 4, F_TICK,         24'h4, 1'b1, 3'd2, 1'b0, 1'b0, 2'd0, 24'h3);
    set_vec( 5, F_LAP,          24'h4, 1'b1, 3'd3, 1'b0, 1'b0, 2'd0, 24'h4);
    set_vec( 6, F_TICK,         24'h5, 1'b1, 3'd3, 1'b0, 1'b0, 2'd0, 24'h4);
    set_vec( 7, F_LAP,          24'h5, 1'b1, 3'd4, 1'b1, 1'b0, 2'd0, 24'h5);
    set_vec( 8, F_TICK,         24'h6, 1'b1, 3'd4, 1'b1, 1'b0, 2'd0, 24'h5);
    set_vec( 9, F_LAP,          24'h6, 1'b1, 3'd4, 1'b1, 1'b0, 2'd0, 24'h6);
    set_vec(10, F_RD,           24'h6, 1'b1, 3'd4, 1'b1, 1'b1, 2'd0, 24'h6);
    set_vec(11, F_TICK,         24'h7, 1'b1, 3'd4, 1'b1, 1'b1, 2'd0, 24'h6);
    set_vec(12, F_RD,           24'h7, 1'b1, 3'd4, 1'b1, 1'b1, 2'd1, 24'h6);
    set_vec(13, F_LAP,          24'h7, 1'b1, 3'd4, 1'b1, 1'b1, 2'd1, 24'h5);
    set_vec(14, F_RD,           24'h7, 1'b1, 3'd4, 1'b1, 1'b1, 2'd2, 24'h5);
    set_vec(15, F_STA,          24'h7, 1'b1, 3'd4, 1'b1, 1'b1, 2'd2, 24'h4);
    set_vec(16, F_RD,           24'h7, 1'b1, 3'd4, 1'b1, 1'b1, 2'd3, 24'h4);
    set_vec(17, F_NONE,         24'h7, 1'b1, 3'd4, 1'b1, 1'b1, 2'd3, 24'h2);
    set_vec(18, F_RD,           24'h7, 1'b1, 3'd4, 1'b1, 1'b0, 2'd0, 24'h2);
    set_vec(19, F_NONE,         24'h7, 1'b1, 3'd4, 1'b1, 1'b0, 2'd0, 24'h7);
    set_vec(20, F_CLR | F_STA | F_LAP, 24'h0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 24'h7);
    set_vec(21, F_TICK,         24'h0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 24'h0);

    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_data_rt",   32'(data_rt),   32'h0);
    check("rst_data_disp", 32'(data_disp), 32'h0);
    check("rst_cnt_en",    32'(cnt_en),    32'h0);
    check("rst_lap_cnt",   32'(lap_cnt),   32'h0);
    check("rst_flags",     32'({disp_mode, full, ovf, expired}), 32'h0);
    rst = 1'b0;

    // Count up 150 ticks, then pause
    step(F_STA);
    check("run_cnt_en", 32'(cnt_en), 32'h1);
    ticks(150);
    check("up150_rt", 32'(data_rt), 32'h150);
    step(F_STA);
    check("pause_cnt_en", 32'(cnt_en), 32'h0);
    ticks(10);
    check("pause_rt", 32'(data_rt), 32'h150);
    check("pause_disp", 32'(data_disp), 32'h150);

    // Stop coincident with tick keeps the increment
    step(F_STA);
    step(F_TICK | F_STA);
    check("tickstop_rt", 32'(data_rt), 32'h151);
    check("tickstop_en", 32'(cnt_en), 32'h0);
    // Read with no laps stored is ignored
    step(F_RD);
    check("rd_empty_dm",  32'(disp_mode), 32'h0);
    check("rd_empty_idx", 32'(lap_idx),   32'h0);

    // Table-driven lap/review sequence
    dir = 1'b0;
    step(F_CLR);
    step(F_STA);
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].flags);
      check($sformatf("v%0d_rt", i),   32'(data_rt),   32'(tbl[i].e_rt));
      check($sformatf("v%0d_en", i),   32'(cnt_en),    32'(tbl[i].e_en));
      check($sformatf("v%0d_cnt", i),  32'(lap_cnt),   32'(tbl[i].e_cnt));
      check($sformatf("v%0d_full", i), 32'(full),      32'(tbl[i].e_full));
      check($sformatf("v%0d_dm", i),   32'(disp_mode), 32'(tbl[i].e_dm));
      check($sformatf("v%0d_idx", i),  32'(lap_idx),   32'(tbl[i].e_idx));
      check($sformatf("v%0d_disp", i), 32'(data_disp), 32'(tbl[i].e_disp));
    end

    // Up-count wrap at 59:59.99: preload near max, then count up
    dir = 1'b1; preset = 24'h595990;
    step(F_CLR);
    check("wrap_preload", 32'(data_rt), 32'h595990);
    dir = 1'b0;
    step(F_STA);
    ticks(9);
    check("wrap_max", 32'(data_rt), 32'h595999);
    check("wrap_ovf0", 32'(ovf), 32'h0);
    ticks(1);
    check("wrap_zero", 32'(data_rt), 32'h0);
    check("wrap_ovf1", 32'(ovf), 32'h1);
    ticks(1);
    check("wrap_sticky", 32'(ovf), 32'h1);
    step(F_CLR);
    check("clr_ovf", 32'(ovf), 32'h0);
    check("clr_rt_up", 32'(data_rt), 32'h0);

    // Countdown from 1.05 s to expiry
    dir = 1'b1; preset = 24'h000105;
    step(F_CLR);
    check("dn_preload", 32'(data_rt), 32'h105);
    step(F_STA);
    ticks(105);
    check("dn_zero", 32'(data_rt), 32'h0);
    check("dn_not_exp", 32'(expired), 32'h0);
    check("dn_running", 32'(cnt_en), 32'h1);
    ticks(1);
    check("dn_expired", 32'(expired), 32'h1);
    check("dn_stopped", 32'(cnt_en), 32'h0);
    step(F_STA);
    ticks(3);
    check("done_sta_ign", 32'(expired), 32'h1);
    check("done_hold", 32'(data_rt), 32'h0);
    step(F_CLR);
    check("done_clr_exp", 32'(expired), 32'h0);
    check("done_clr_rt", 32'(data_rt), 32'h105);

    // Asynchronous reset between edges while running
    dir = 1'b0;
    step(F_CLR);
    step(F_STA);
    ticks(5);
    check("pre_arst_rt", 32'(data_rt), 32'h5);
    #3 rst = 1'b1;
    #1;
    check("arst_rt",   32'(data_rt),   32'h0);
    check("arst_disp", 32'(data_disp), 32'h0);
    check("arst_en",   32'(cnt_en),    32'h0);
    #1 rst = 1'b0;
    ticks(3);
    check("post_arst_idle_rt", 32'(data_rt), 32'h0);
    check("post_arst_idle_en", 32'(cnt_en),  32'h0);
    step(F_STA);
    check("post_arst_start", 32'(cnt_en), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
